// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and fetch controller for an in-order pipeline.
// Generates per-register load enables and valid bits, handles load-use and
// data-memory stalls, branch redirects, and parks an early I-cache response
// in a skid register while the front end is frozen.
//
// state | meaning
// FETCH | imem request outstanding, response goes straight into reg 0
// DROP  | stale imem response from before a redirect is still due; discard it
// HELD  | response captured in the skid register, waiting for the stall to clear
module pipeline_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int MEM_REG    = 2,
    parameter int REG_W      = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    output logic                  imem_read,
    input  logic                  dmem_op,
    input  logic                  dmem_resp,
    input  logic                  redirect,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic [1:0]            id_src_used,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic                  ex_is_load,
    output logic                  pc_en,
    output logic                  pc_sel_redirect,
    output logic [NUM_STAGES-2:0] stage_en,
    output logic [NUM_STAGES-2:0] stage_valid,
    output logic                  skid_load,
    output logic                  ifid_from_skid,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int NREG = NUM_STAGES - 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HELD  = 2'd2
    } fetch_state_t;

    fetch_state_t    state, state_nxt;
    logic [NREG-1:0] valid, valid_nxt;
    logic [NREG-1:0] stage_en_c;
    logic            dstall, lu_stall, redir, stall_any;
    logic            rs1_hit, rs2_hit;
    logic            en0, v0_nxt, fetch_adv;
    logic            read_c, skid_c, from_skid_c;

    assign rs1_hit   = id_src_used[0] && (id_rs1 == ex_rd);
    assign rs2_hit   = id_src_used[1] && (id_rs2 == ex_rd);
    assign dstall    = valid[MEM_REG] & dmem_op & ~dmem_resp;
    assign lu_stall  = valid[0] & valid[1] & ex_is_load & (ex_rd != '0) & (rs1_hit | rs2_hit);
    assign redir     = valid[MEM_REG] & redirect & ~dstall;
    assign stall_any = dstall | lu_stall;

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    // Fetch FSM next state and reg-0 control; a frozen reg 0 keeps its valid bit.
    always_comb begin
        state_nxt   = state;
        read_c      = 1'b0;
        skid_c      = 1'b0;
        from_skid_c = 1'b0;
        en0         = 1'b0;
        v0_nxt      = valid[0];
        fetch_adv   = 1'b0;
        case (state)
            FETCH: begin
                read_c = 1'b1;
                if (redir) begin
                    en0    = 1'b1;
                    v0_nxt = 1'b0;
                    if (!imem_resp) state_nxt = DROP;
                end else if (stall_any && imem_resp) begin
                    skid_c    = 1'b1;
                    state_nxt = HELD;
                end else if (imem_resp) begin
                    en0       = 1'b1;
                    v0_nxt    = 1'b1;
                    fetch_adv = 1'b1;
                end else begin
                    en0    = ~stall_any;
                    v0_nxt = stall_any ? valid[0] : 1'b0;
                end
            end
            DROP: begin
                read_c = 1'b1;
                en0    = 1'b1;
                v0_nxt = 1'b0;
                if (imem_resp && !redir) state_nxt = FETCH;
            end
            HELD: begin
                if (redir) begin
                    en0       = 1'b1;
                    v0_nxt    = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall_any) begin
                    from_skid_c = 1'b1;
                    en0         = 1'b1;
                    v0_nxt      = 1'b1;
                    fetch_adv   = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Valid-bit propagation: dstall freezes 1..MEM_REG and bubbles MEM_REG+1.
    always_comb begin
        valid_nxt    = valid;
        valid_nxt[0] = v0_nxt;
        for (int k = 1; k <= MEM_REG; k++) begin
            if (redir)                valid_nxt[k] = 1'b0;
            else if (dstall)          valid_nxt[k] = valid[k];
            else if (k == 1 && lu_stall) valid_nxt[k] = 1'b0;
            else                      valid_nxt[k] = valid[k-1];
        end
        valid_nxt[MEM_REG+1] = valid[MEM_REG] & ~dstall;
        for (int k = MEM_REG + 2; k < NREG; k++) begin
            valid_nxt[k] = valid[k-1];
        end
    end

    // Per-register load enables.
    always_comb begin
        stage_en_c    = '1;
        stage_en_c[0] = en0;
        for (int k = 1; k <= MEM_REG; k++) begin
            stage_en_c[k] = ~dstall;
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid <= '0;
        else      valid <= valid_nxt;
    end

    // Saturating stall and redirect counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_any && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (redir && flush_count != '1)      flush_count  <= flush_count + CNT_W'(1);
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign imem_read       = rst & read_c;
    assign skid_load       = rst & skid_c;
    assign ifid_from_skid  = rst & from_skid_c;
    assign pc_sel_redirect = rst & redir;
    assign pc_en           = rst & (redir | fetch_adv);
    assign stage_en        = rst ? stage_en_c : '0;
    assign stage_valid     = valid;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a slot/flag-based reference model.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_resp, dmem_op, dmem_resp, redirect, ex_is_load;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic [1:0]    id_src_used;
    logic          imem_read, pc_en, pc_sel_redirect, skid_load, ifid_from_skid;
    logic [3:0]    stage_en, stage_valid;
    logic [CW-1:0] stall_cycles, flush_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: slot occupancy, a parked-instruction flag, a stale-response flag.
    logic [3:0]    mv;
    bit            m_skid, m_drop;
    logic [CW-1:0] m_stall, m_flush;
    logic [3:0]    m_nv, e_en;
    bit            n_skid, n_drop, m_any, m_rd;
    logic          e_read, e_pc_en, e_sel, e_skid_load, e_from_skid;
    logic          last_read, last_pc_en, last_skid_load, last_from_skid;
    logic [3:0]    last_en;

    pipeline_ctrl #(.NUM_STAGES(5), .MEM_REG(2), .REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .imem_resp(imem_resp), .imem_read(imem_read),
        .dmem_op(dmem_op), .dmem_resp(dmem_resp), .redirect(redirect),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_src_used(id_src_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
        .stage_en(stage_en), .stage_valid(stage_valid),
        .skid_load(skid_load), .ifid_from_skid(ifid_from_skid),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_resp = 0; dmem_op = 0; dmem_resp = 0; redirect = 0; ex_is_load = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_src_used = 0;
    endtask

    task automatic model_reset();
        mv = '0; m_skid = 0; m_drop = 0; m_stall = '0; m_flush = '0;
    endtask

    task automatic model_eval();
        bit ds, lu, hit, adv, en0;
        logic nv0;
        ds  = mv[2] && dmem_op && !dmem_resp;
        hit = (id_src_used[0] && id_rs1 == ex_rd) || (id_src_used[1] && id_rs2 == ex_rd);
        lu  = mv[0] && mv[1] && ex_is_load && (ex_rd != 0) && hit;
        m_rd  = mv[2] && redirect && !ds;
        m_any = ds || lu;
        adv = 0; e_skid_load = 0; e_from_skid = 0;
        n_skid = m_skid; n_drop = m_drop;
        e_read = !m_skid;
        if (m_rd) begin
            en0 = 1; nv0 = 0; n_skid = 0;
            n_drop = m_drop ? 1'b1 : (m_skid ? 1'b0 : !imem_resp);
        end else if (m_drop) begin
            en0 = 1; nv0 = 0;
            if (imem_resp) n_drop = 0;
        end else if (m_skid) begin
            if (!m_any) begin
                en0 = 1; nv0 = 1; adv = 1; e_from_skid = 1; n_skid = 0;
            end else begin
                en0 = 0; nv0 = mv[0];
            end
        end else if (imem_resp) begin
            if (m_any) begin
                e_skid_load = 1; n_skid = 1; en0 = 0; nv0 = mv[0];
            end else begin
                en0 = 1; nv0 = 1; adv = 1;
            end
        end else begin
            en0 = !m_any; nv0 = en0 ? 1'b0 : mv[0];
        end
        e_sel   = m_rd;
        e_pc_en = m_rd || adv;
        e_en    = {1'b1, !ds, !ds, en0};
        m_nv[3] = mv[2] && !ds;
        m_nv[2] = m_rd ? 1'b0 : (ds ? mv[2] : mv[1]);
        m_nv[1] = m_rd ? 1'b0 : (ds ? mv[1] : (lu ? 1'b0 : mv[0]));
        m_nv[0] = nv0;
    endtask

    task automatic model_commit();
        mv = m_nv; m_skid = n_skid; m_drop = n_drop;
        if (m_any && m_stall != '1) m_stall = m_stall + 1'b1;
        if (m_rd && m_flush != '1)  m_flush = m_flush + 1'b1;
    endtask

    // One clock cycle; entered and left at posedge+1 with inputs already driven.
    task automatic step();
        #2;
        model_eval();
        last_read = imem_read; last_pc_en = pc_en; last_en = stage_en;
        last_skid_load = skid_load; last_from_skid = ifid_from_skid;
        chk("imem_read", imem_read, e_read);
        chk("pc_en", pc_en, e_pc_en);
        chk("pc_sel_redirect", pc_sel_redirect, e_sel);
        chk("stage_en", stage_en, e_en);
        chk("skid_load", skid_load, e_skid_load);
        chk("ifid_from_skid", ifid_from_skid, e_from_skid);
        @(posedge clk); #1;
        model_commit();
        chk("stage_valid", stage_valid, mv);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_count", flush_count, m_flush);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_read"}, imem_read, 0);
        chk({tag, "_pc_en"}, pc_en, 0);
        chk({tag, "_pc_sel"}, pc_sel_redirect, 0);
        chk({tag, "_stage_en"}, stage_en, 0);
        chk({tag, "_skid_load"}, skid_load, 0);
        chk({tag, "_from_skid"}, ifid_from_skid, 0);
        chk({tag, "_valid"}, stage_valid, 0);
        chk({tag, "_stall_cnt"}, stall_cycles, 0);
        chk({tag, "_flush_cnt"}, flush_count, 0);
    endtask

    initial begin
        int skid_pulses, read_zero;
        rst = 0;
        clear_inputs();
        model_reset();
        imem_resp = 1; redirect = 1;
        repeat (2) @(posedge clk);
        #3;
        chk_reset("por");
        @(posedge clk); #1;
        clear_inputs();
        rst = 1;

        // First cycle out of reset requests a fetch.
        step();
        chk("first_read", last_read, 1);

        // Streaming fill.
        for (int i = 0; i < 8; i++) begin
            imem_resp = 1;
            step();
            if (i < 4) chk("fill", stage_valid, 32'((1 << (i + 1)) - 1));
            chk("stream_pc_en", last_pc_en, 1);
        end
        chk("stream_stall", stall_cycles, 0);
        chk("stream_flush", flush_count, 0);

        // Load-use hazard on rs1.
        imem_resp = 0; ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_src_used = 2'b01;
        step();
        chk("lu_en0", last_en[0], 0);
        chk("lu_v1", stage_valid[1], 0);
        chk("lu_cnt", stall_cycles, 1);
        ex_is_load = 0; imem_resp = 1;
        step();
        chk("lu_release_en0", last_en[0], 1);
        step(); step();
        chk("refill", stage_valid, 4'hF);

        // D-cache miss for four cycles.
        imem_resp = 0; dmem_op = 1; dmem_resp = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dmiss_en", last_en[2:0], 0);
            chk("dmiss_v3", stage_valid[3], 0);
        end
        chk("dmiss_cnt", stall_cycles, 5);
        dmem_resp = 1; imem_resp = 1;
        step();
        chk("dmiss_release_en", last_en, 4'hF);

        // I-cache response during a three-cycle D-cache stall.
        skid_pulses = 0; read_zero = 0;
        dmem_resp = 0; imem_resp = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) imem_resp = 0;
            if (i == 3) dmem_resp = 1;
            step();
            skid_pulses += int'(last_skid_load);
            read_zero   += int'(!last_read);
        end
        chk("held_skid_pulses", skid_pulses, 1);
        chk("held_read_zero", read_zero, 3);
        chk("held_from_skid", last_from_skid, 1);
        chk("held_v0", stage_valid[0], 1);
        chk("held_cnt", stall_cycles, 8);

        // Redirect with a fetch outstanding, then a stale response.
        dmem_op = 0; dmem_resp = 0; redirect = 1; imem_resp = 0;
        step();
        chk("redir_front", stage_valid[2:0], 0);
        chk("redir_flush", flush_count, 1);
        redirect = 0; imem_resp = 1;
        step();
        chk("drop_v0", stage_valid[0], 0);
        chk("drop_pc_en", last_pc_en, 0);
        step();
        chk("after_drop_fetch", stage_valid, 4'h1);

        // Reset asserted while in DROP.
        step();
        imem_resp = 1;
        step();
        redirect = 1; imem_resp = 0;
        step();
        chk("pre_rst_flush", flush_count, 2);
        redirect = 0;
        #1 rst = 0;
        #1;
        chk_reset("drop_rst");
        model_reset();
        imem_resp = 1;
        @(posedge clk); #1;
        chk_reset("drop_rst_hold");
        rst = 1;
        step();
        chk("late_resp_v", stage_valid, 4'h1);

        // Random traffic, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            imem_resp   = 1'($urandom_range(0, 1));
            dmem_op     = ($urandom_range(0, 3) == 0);
            dmem_resp   = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 5) == 0);
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_src_used = 2'($urandom_range(0, 3));
            if (i == 300) begin
                #1 rst = 0;
                #1;
                chk_reset("rand_rst");
                model_reset();
                @(posedge clk); #1;
                rst = 1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
